// File: rtl/gpgpu_pkg.sv
// Shared types for the per-warp front end: register tags and instruction buffer sizing.
// No logic beyond a small mask helper; no latency.
// No flow control.
package gpgpu_pkg;
    localparam int TAG_W     = 6;
    localparam int REG_IDX_W = 5;
    localparam int IB_DEPTH  = 4;

    typedef struct packed {
        logic                 used;
        logic [REG_IDX_W-1:0] idx;
    } reg_tag_t;

    // Entries 0..cnt-1 are occupied.
    function automatic logic [IB_DEPTH-1:0] ib_prefix_mask(input logic [2:0] cnt);
        logic [IB_DEPTH-1:0] m;
        m = '0;
        for (int j = 0; j < IB_DEPTH; j++) begin
            m[j] = (3'(j) < cnt);
        end
        return m;
    endfunction
endpackage

// File: rtl/ib_issue_select.sv
// Oldest-ready picker: priority-encodes the ready vector, lowest index wins.
// Purely combinational, zero latency.
// No flow control; the caller gates the result with grant/backpressure.
module ib_issue_select
    import gpgpu_pkg::*;
(
    input  logic [IB_DEPTH-1:0]         rdy,
    output logic [$clog2(IB_DEPTH)-1:0] sel,
    output logic [IB_DEPTH-1:0]         onehot,
    output logic                        any
);
    always_comb begin
        sel    = '0;
        onehot = '0;
        for (int j = IB_DEPTH - 1; j >= 0; j--) begin
            if (rdy[j]) begin
                sel       = ($clog2(IB_DEPTH))'(j);
                onehot    = '0;
                onehot[j] = 1'b1;
            end
        end
        any = |rdy;
    end
endmodule

// File: rtl/ibuffer_warp.sv
// Per-warp 4-entry in-order instruction buffer feeding the issue arbiter.
// Write visible next cycle; ready bits need one more cycle; issue fires in the grant cycle.
// Decode stalls on IB_Full (registered); SB_Full or Flush suppress the issue request.
module ibuffer_warp
    import gpgpu_pkg::*;
#(
    parameter int INST_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                Dec_Valid,
    input  logic [INST_W-1:0]   Dec_Inst,
    input  logic [TAG_W-1:0]    Dec_Src1,
    input  logic [TAG_W-1:0]    Dec_Src2,
    input  logic [TAG_W-1:0]    Dec_Dst,
    output logic                IB_Full,
    output logic [IB_DEPTH-1:0] IB_Inst_Valid_SB,
    output logic [TAG_W-1:0]    IB_Src1_Entry0_SB,
    output logic [TAG_W-1:0]    IB_Src1_Entry1_SB,
    output logic [TAG_W-1:0]    IB_Src1_Entry2_SB,
    output logic [TAG_W-1:0]    IB_Src1_Entry3_SB,
    output logic [TAG_W-1:0]    IB_Src2_Entry0_SB,
    output logic [TAG_W-1:0]    IB_Src2_Entry1_SB,
    output logic [TAG_W-1:0]    IB_Src2_Entry2_SB,
    output logic [TAG_W-1:0]    IB_Src2_Entry3_SB,
    output logic [TAG_W-1:0]    IB_Dst_Entry0_SB,
    output logic [TAG_W-1:0]    IB_Dst_Entry1_SB,
    output logic [TAG_W-1:0]    IB_Dst_Entry2_SB,
    output logic [TAG_W-1:0]    IB_Dst_Entry3_SB,
    input  logic [IB_DEPTH-1:0] SB_Ready_Issue_IB,
    input  logic                SB_Full,
    output logic [IB_DEPTH-1:0] IB_Issued_SB,
    output logic                IB_Req_Issue,
    input  logic                Issue_Grant,
    output logic [INST_W-1:0]   IB_Issue_Inst,
    input  logic                Flush
);
    logic [INST_W-1:0] inst_q [DEPTH];
    logic [INST_W-1:0] inst_n [DEPTH];
    reg_tag_t          src1_q [DEPTH];
    reg_tag_t          src1_n [DEPTH];
    reg_tag_t          src2_q [DEPTH];
    reg_tag_t          src2_n [DEPTH];
    reg_tag_t          dst_q  [DEPTH];
    reg_tag_t          dst_n  [DEPTH];

    logic [DEPTH-1:0] valid_q, valid_n, rdy_q, rdy_n;
    logic [2:0]       count_q, count_n, cnt_after;
    logic [1:0]       sel;
    logic [DEPTH-1:0] sel_onehot;
    logic             any_rdy, fire, wr;

    ib_issue_select u_sel (
        .rdy    (rdy_q),
        .sel    (sel),
        .onehot (sel_onehot),
        .any    (any_rdy)
    );

    assign IB_Full          = (count_q == 3'(DEPTH));
    assign IB_Req_Issue     = any_rdy & ~SB_Full & ~Flush;
    assign fire             = IB_Req_Issue & Issue_Grant;
    assign IB_Issued_SB     = fire ? sel_onehot : '0;
    assign IB_Issue_Inst    = inst_q[sel];
    assign wr               = Dec_Valid & ~IB_Full & ~Flush;
    assign IB_Inst_Valid_SB = valid_q;

    assign IB_Src1_Entry0_SB = src1_q[0];
    assign IB_Src1_Entry1_SB = src1_q[1];
    assign IB_Src1_Entry2_SB = src1_q[2];
    assign IB_Src1_Entry3_SB = src1_q[3];
    assign IB_Src2_Entry0_SB = src2_q[0];
    assign IB_Src2_Entry1_SB = src2_q[1];
    assign IB_Src2_Entry2_SB = src2_q[2];
    assign IB_Src2_Entry3_SB = src2_q[3];
    assign IB_Dst_Entry0_SB  = dst_q[0];
    assign IB_Dst_Entry1_SB  = dst_q[1];
    assign IB_Dst_Entry2_SB  = dst_q[2];
    assign IB_Dst_Entry3_SB  = dst_q[3];

    always_comb begin
        inst_n    = inst_q;
        src1_n    = src1_q;
        src2_n    = src2_q;
        dst_n     = dst_q;
        cnt_after = count_q - {2'b00, fire};
        // Compact: everything above the issued slot slides down one.
        for (int j = 0; j < DEPTH - 1; j++) begin
            if (fire && j >= int'(sel)) begin
                inst_n[j] = inst_q[j+1];
                src1_n[j] = src1_q[j+1];
                src2_n[j] = src2_q[j+1];
                dst_n[j]  = dst_q[j+1];
            end
        end
        for (int j = 0; j < DEPTH; j++) begin
            if (wr && cnt_after == 3'(j)) begin
                inst_n[j] = Dec_Inst;
                src1_n[j] = reg_tag_t'(Dec_Src1);
                src2_n[j] = reg_tag_t'(Dec_Src2);
                dst_n[j]  = reg_tag_t'(Dec_Dst);
            end
        end
        count_n = Flush ? 3'd0 : cnt_after + {2'b00, wr};
        valid_n = ib_prefix_mask(count_n);
        // Indices shift and the scoreboard gains an entry on issue, so old bits are stale.
        rdy_n   = (fire || Flush) ? '0 : (SB_Ready_Issue_IB & valid_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            rdy_q   <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_n;
            rdy_q   <= rdy_n;
            count_q <= count_n;
        end
    end

    always_ff @(posedge clk) begin
        inst_q <= inst_n;
        src1_q <= src1_n;
        src2_q <= src2_n;
        dst_q  <= dst_n;
    end
endmodule

// File: tb/tb_ibuffer_warp.sv
module tb_ibuffer_warp;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        Dec_Valid;
    logic [31:0] Dec_Inst;
    logic [5:0]  Dec_Src1, Dec_Src2, Dec_Dst;
    logic        IB_Full;
    logic [3:0]  IB_Inst_Valid_SB;
    logic [5:0]  s1_0, s1_1, s1_2, s1_3;
    logic [5:0]  s2_0, s2_1, s2_2, s2_3;
    logic [5:0]  d_0, d_1, d_2, d_3;
    logic [3:0]  SB_Ready_Issue_IB;
    logic        SB_Full;
    logic [3:0]  IB_Issued_SB;
    logic        IB_Req_Issue;
    logic        Issue_Grant;
    logic [31:0] IB_Issue_Inst;
    logic        Flush;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ibuffer_warp #(.INST_W(32), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .Dec_Valid(Dec_Valid), .Dec_Inst(Dec_Inst),
        .Dec_Src1(Dec_Src1), .Dec_Src2(Dec_Src2), .Dec_Dst(Dec_Dst),
        .IB_Full(IB_Full), .IB_Inst_Valid_SB(IB_Inst_Valid_SB),
        .IB_Src1_Entry0_SB(s1_0), .IB_Src1_Entry1_SB(s1_1),
        .IB_Src1_Entry2_SB(s1_2), .IB_Src1_Entry3_SB(s1_3),
        .IB_Src2_Entry0_SB(s2_0), .IB_Src2_Entry1_SB(s2_1),
        .IB_Src2_Entry2_SB(s2_2), .IB_Src2_Entry3_SB(s2_3),
        .IB_Dst_Entry0_SB(d_0), .IB_Dst_Entry1_SB(d_1),
        .IB_Dst_Entry2_SB(d_2), .IB_Dst_Entry3_SB(d_3),
        .SB_Ready_Issue_IB(SB_Ready_Issue_IB), .SB_Full(SB_Full),
        .IB_Issued_SB(IB_Issued_SB), .IB_Req_Issue(IB_Req_Issue),
        .Issue_Grant(Issue_Grant), .IB_Issue_Inst(IB_Issue_Inst),
        .Flush(Flush)
    );

    // Decode must never write while the buffer reports full.
    always @(posedge clk) begin
        if (rst_n === 1'b1 && Dec_Valid === 1'b1 && IB_Full === 1'b1)
            $error("decode wrote while IB_Full");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; Dec_Valid = 0; Dec_Inst = 0; Dec_Src1 = 0; Dec_Src2 = 0; Dec_Dst = 0;
        SB_Ready_Issue_IB = 0; SB_Full = 0; Issue_Grant = 0; Flush = 0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    // Entry i of a fill gets src1={1,i+1}, src2={1,i+9}, dst={1,i+17}.
    task automatic write_one(input logic [31:0] inst, input int i);
        Dec_Valid = 1'b1; Dec_Inst = inst;
        Dec_Src1 = {1'b1, 5'(i + 1)}; Dec_Src2 = {1'b1, 5'(i + 9)}; Dec_Dst = {1'b1, 5'(i + 17)};
        step();
        Dec_Valid = 1'b0;
    endtask

    task automatic fill(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) write_one(base + 32'(i), i);
    endtask

    task automatic test_reset;
        do_reset();
        n_tests++;
        if ({IB_Full, IB_Req_Issue, IB_Issued_SB, IB_Inst_Valid_SB} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got full=%b req=%b issued=%b valid=%b, want all 0",
                     IB_Full, IB_Req_Issue, IB_Issued_SB, IB_Inst_Valid_SB);
        end
    endtask

    task automatic test_fill_issue;
        do_reset();
        SB_Ready_Issue_IB = 4'b1111;
        fill(4, 32'd100);
        n_tests++;
        if (IB_Full !== 1'b1 || IB_Inst_Valid_SB !== 4'b1111) begin
            n_fail++;
            $display("FAIL fill_full: got full=%b valid=%b, want 1 1111", IB_Full, IB_Inst_Valid_SB);
        end
        n_tests++;
        if (s1_2 !== 6'h23 || s2_3 !== 6'h2c || d_0 !== 6'h31) begin
            n_fail++;
            $display("FAIL fill_tags: got s1_2=%h s2_3=%h d_0=%h, want 23 2c 31", s1_2, s2_3, d_0);
        end
        step();
        n_tests++;
        if (IB_Req_Issue !== 1'b1 || IB_Issue_Inst !== 32'd100) begin
            n_fail++;
            $display("FAIL fill_req: got req=%b inst=%0d, want 1 100", IB_Req_Issue, IB_Issue_Inst);
        end
        Issue_Grant = 1'b1;
        #1;
        n_tests++;
        if (IB_Issued_SB !== 4'b0001) begin
            n_fail++;
            $display("FAIL fill_issued: got %b want 0001", IB_Issued_SB);
        end
        step();
        Issue_Grant = 1'b0;
        n_tests++;
        if (IB_Req_Issue !== 1'b0 || IB_Inst_Valid_SB !== 4'b0111 || IB_Full !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_after_issue: got req=%b valid=%b full=%b, want 0 0111 0",
                     IB_Req_Issue, IB_Inst_Valid_SB, IB_Full);
        end
        step();
        n_tests++;
        if (IB_Req_Issue !== 1'b1 || IB_Issue_Inst !== 32'd101) begin
            n_fail++;
            $display("FAIL fill_resample: got req=%b inst=%0d, want 1 101", IB_Req_Issue, IB_Issue_Inst);
        end
    endtask

    task automatic test_mid_issue;
        do_reset();
        SB_Ready_Issue_IB = 4'b0100;
        fill(4, 32'd200);
        step();
        n_tests++;
        if (IB_Req_Issue !== 1'b1 || IB_Issue_Inst !== 32'd202) begin
            n_fail++;
            $display("FAIL mid_req: got req=%b inst=%0d, want 1 202", IB_Req_Issue, IB_Issue_Inst);
        end
        Issue_Grant = 1'b1;
        #1;
        n_tests++;
        if (IB_Issued_SB !== 4'b0100) begin
            n_fail++;
            $display("FAIL mid_issued: got %b want 0100", IB_Issued_SB);
        end
        step();
        Issue_Grant = 1'b0;
        n_tests++;
        if (IB_Inst_Valid_SB !== 4'b0111 || IB_Req_Issue !== 1'b0 || d_2 !== 6'h34 || s1_1 !== 6'h22) begin
            n_fail++;
            $display("FAIL mid_compact: got valid=%b req=%b d_2=%h s1_1=%h, want 0111 0 34 22",
                     IB_Inst_Valid_SB, IB_Req_Issue, d_2, s1_1);
        end
        step();
        n_tests++;
        if (IB_Req_Issue !== 1'b1 || IB_Issue_Inst !== 32'd203) begin
            n_fail++;
            $display("FAIL mid_resample: got req=%b inst=%0d, want 1 203", IB_Req_Issue, IB_Issue_Inst);
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        SB_Ready_Issue_IB = 4'b0001;
        fill(2, 32'd300);
        step();
        Dec_Valid = 1'b1; Dec_Inst = 32'd302;
        Dec_Src1 = 6'h2a; Dec_Src2 = 6'h0b; Dec_Dst = 6'h3c;
        Issue_Grant = 1'b1;
        #1;
        n_tests++;
        if (IB_Issued_SB !== 4'b0001) begin
            n_fail++;
            $display("FAIL b2b_issued: got %b want 0001", IB_Issued_SB);
        end
        step();
        Dec_Valid = 1'b0; Issue_Grant = 1'b0;
        n_tests++;
        if (IB_Inst_Valid_SB !== 4'b0011 || IB_Full !== 1'b0 || s1_1 !== 6'h2a || d_1 !== 6'h3c || s2_0 !== 6'h2a) begin
            n_fail++;
            $display("FAIL b2b_state: got valid=%b full=%b s1_1=%h d_1=%h s2_0=%h, want 0011 0 2a 3c 2a",
                     IB_Inst_Valid_SB, IB_Full, s1_1, d_1, s2_0);
        end
        SB_Ready_Issue_IB = 4'b0010;
        step();
        n_tests++;
        if (IB_Req_Issue !== 1'b1 || IB_Issue_Inst !== 32'd302) begin
            n_fail++;
            $display("FAIL b2b_new_entry: got req=%b inst=%0d, want 1 302", IB_Req_Issue, IB_Issue_Inst);
        end
    endtask

    task automatic test_sb_full;
        do_reset();
        SB_Ready_Issue_IB = 4'b0011;
        fill(2, 32'd400);
        step();
        SB_Full = 1'b1; Issue_Grant = 1'b1;
        #1;
        n_tests++;
        if (IB_Req_Issue !== 1'b0 || IB_Issued_SB !== 4'b0000) begin
            n_fail++;
            $display("FAIL sbfull_block: got req=%b issued=%b, want 0 0000", IB_Req_Issue, IB_Issued_SB);
        end
        step();
        Issue_Grant = 1'b0;
        n_tests++;
        if (IB_Inst_Valid_SB !== 4'b0011) begin
            n_fail++;
            $display("FAIL sbfull_hold: got valid=%b want 0011", IB_Inst_Valid_SB);
        end
        SB_Full = 1'b0;
        step();
        n_tests++;
        if (IB_Req_Issue !== 1'b1 || IB_Issue_Inst !== 32'd400) begin
            n_fail++;
            $display("FAIL sbfull_release: got req=%b inst=%0d, want 1 400", IB_Req_Issue, IB_Issue_Inst);
        end
    endtask

    task automatic test_flush;
        do_reset();
        SB_Ready_Issue_IB = 4'b1111;
        fill(2, 32'd500);
        step();
        Flush = 1'b1; Issue_Grant = 1'b1;
        Dec_Valid = 1'b1; Dec_Inst = 32'd599; Dec_Src1 = 6'h21; Dec_Src2 = 6'h22; Dec_Dst = 6'h23;
        #1;
        n_tests++;
        if (IB_Issued_SB !== 4'b0000 || IB_Req_Issue !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_issued: got issued=%b req=%b, want 0000 0", IB_Issued_SB, IB_Req_Issue);
        end
        step();
        Flush = 1'b0; Issue_Grant = 1'b0; Dec_Valid = 1'b0;
        n_tests++;
        if (IB_Inst_Valid_SB !== 4'b0000 || IB_Full !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_clear: got valid=%b full=%b, want 0000 0", IB_Inst_Valid_SB, IB_Full);
        end
        step();
        n_tests++;
        if (IB_Req_Issue !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_req: got req=%b want 0", IB_Req_Issue);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        SB_Ready_Issue_IB = 4'b1111;
        fill(3, 32'd600);
        step();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({IB_Full, IB_Req_Issue, IB_Issued_SB, IB_Inst_Valid_SB} !== 10'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got full=%b req=%b issued=%b valid=%b, want all 0",
                     IB_Full, IB_Req_Issue, IB_Issued_SB, IB_Inst_Valid_SB);
        end
        step();
        rst_n = 1'b1;
        #1;
        write_one(32'd650, 5);
        n_tests++;
        if (IB_Inst_Valid_SB !== 4'b0001 || s1_0 !== 6'h26 || d_0 !== 6'h36) begin
            n_fail++;
            $display("FAIL midreset_write: got valid=%b s1_0=%h d_0=%h, want 0001 26 36",
                     IB_Inst_Valid_SB, s1_0, d_0);
        end
        step();
        n_tests++;
        if (IB_Req_Issue !== 1'b1 || IB_Issue_Inst !== 32'd650) begin
            n_fail++;
            $display("FAIL midreset_issue: got req=%b inst=%0d, want 1 650", IB_Req_Issue, IB_Issue_Inst);
        end
    endtask

    initial begin
        test_reset();
        test_fill_issue();
        test_mid_issue();
        test_back_to_back();
        test_sb_full();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
